capture_trigger: RTL and testbench

CAPTURE_TRIGGER -- requirements
Module: capture_trigger

---
 rtl/pdh_capture_pkg.sv | 34 +++
 rtl/level_crossing_detector.sv | 31 +++
 rtl/capture_trigger.sv | 153 +++++++++++++++
 tb/tb_capture_trigger.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdh_capture_pkg.sv
// Shared types for the PDH capture trigger block.
// Trigger modes, FSM states and the capture-word packing helper.
package pdh_capture_pkg;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'd0,
        TRIG_RISING    = 2'd1,
        TRIG_FALLING   = 2'd2,
        TRIG_EXT       = 2'd3
    } trig_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_ARMED     = 3'd2,
        ST_FIRE      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } cap_state_t;

    localparam int TS_W   = 32;
    localparam int CH_W   = 16;
    localparam int DATA_W = 4 * CH_W;

    // Channel A lands in the most significant slice.
    function automatic logic [DATA_W-1:0] pack_channels(
        input logic [CH_W-1:0] a,
        input logic [CH_W-1:0] b,
        input logic [CH_W-1:0] c,
        input logic [CH_W-1:0] d
    );
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/level_crossing_detector.sv
// Signed threshold crossing detector with a one-sample history.
// History is invalidated while clear is high, so the first sample after clear never hits.
module level_crossing_detector #(
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic signed [TW-1:0] src,
    input  logic signed [TW-1:0] threshold,
    output logic                 hit_rise,
    output logic                 hit_fall
);

    logic signed [TW-1:0] prev;
    logic                 prev_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev       <= src;
            prev_valid <= !clear;
        end
    end

    assign hit_rise = prev_valid && (prev < threshold) && (src >= threshold);
    assign hit_fall = prev_valid && (prev > threshold) && (src <= threshold);

endmodule

// File: rtl/capture_trigger.sv
// Trigger and handshake sequencer for the PDH capture engine.
// Arms, waits out holdoff, detects a trigger, then starts and supervises one capture.
module capture_trigger #(
    parameter int TW            = 16,
    parameter int HW            = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 pdh_clk,
    input  logic                 rst_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic [1:0]           trig_mode_i,
    input  logic signed [TW-1:0] trig_src_i,
    input  logic                 trig_ext_i,
    input  logic signed [TW-1:0] threshold_i,
    input  logic [HW-1:0]        holdoff_i,
    input  logic [15:0]          ch_a_i,
    input  logic [15:0]          ch_b_i,
    input  logic [15:0]          ch_c_i,
    input  logic [15:0]          ch_d_i,
    input  logic                 bram_ready_i,
    output logic                 enable_o,
    output logic [63:0]          data_o,
    output logic                 armed_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          trig_ts_o
);

    import pdh_capture_pkg::*;

    localparam int TO_W = $clog2(START_TIMEOUT + 1);

    cap_state_t      state;
    cap_state_t      state_n;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_n;
    logic [TO_W-1:0] fire_cnt;
    logic [TO_W-1:0] fire_n;
    logic [TS_W-1:0] ts;
    logic            err_n;
    logic            done_n;
    logic            latch_ts;
    logic            hit;
    logic            hit_rise;
    logic            hit_fall;

    level_crossing_detector #(
        .TW(TW)
    ) u_detect (
        .clk      (pdh_clk),
        .rst      (rst_i),
        .clear    (state != ST_ARMED),
        .src      (trig_src_i),
        .threshold(threshold_i),
        .hit_rise (hit_rise),
        .hit_fall (hit_fall)
    );

    always_comb begin
        hit = 1'b0;
        unique case (trig_mode_t'(trig_mode_i))
            TRIG_IMMEDIATE: hit = 1'b1;
            TRIG_RISING:    hit = hit_rise;
            TRIG_FALLING:   hit = hit_fall;
            TRIG_EXT:       hit = trig_ext_i;
        endcase
    end

    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        fire_n   = fire_cnt;
        err_n    = err_o;
        done_n   = 1'b0;
        latch_ts = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arm_i && bram_ready_i) begin
                    err_n   = 1'b0;
                    hold_n  = holdoff_i;
                    state_n = (holdoff_i == '0) ? ST_ARMED : ST_HOLDOFF;
                end else if (arm_i) begin
                    err_n = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (abort_i) begin
                    hold_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    hold_n = hold_cnt - 1'b1;
                    if (hold_cnt == HW'(1)) state_n = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Abort wins over a hit landing in the same cycle.
                if (abort_i) begin
                    state_n = ST_IDLE;
                end else if (hit) begin
                    latch_ts = 1'b1;
                    fire_n   = '0;
                    state_n  = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (!bram_ready_i) begin
                    state_n = ST_WAIT_DONE;
                end else if (fire_cnt == TO_W'(START_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    fire_n = fire_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bram_ready_i) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are glitch-free flops.
    always_ff @(posedge pdh_clk) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            fire_cnt  <= '0;
            ts        <= '0;
            enable_o  <= 1'b0;
            armed_o   <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            trig_ts_o <= '0;
            data_o    <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            fire_cnt <= fire_n;
            ts       <= ts + 1'b1;
            enable_o <= (state_n == ST_FIRE);
            armed_o  <= (state_n == ST_HOLDOFF) || (state_n == ST_ARMED);
            done_o   <= done_n;
            err_o    <= err_n;
            data_o   <= pack_channels(ch_a_i, ch_b_i, ch_c_i, ch_d_i);
            if (latch_ts) trig_ts_o <= ts;
        end
    end

endmodule

// File: tb/tb_capture_trigger.sv
// Randomized scoreboard bench for capture_trigger.
// A trigger model predicts output events; a monitor pops and compares them as they appear.
module tb_capture_trigger;

    localparam int TW = 16;
    localparam int HW = 16;
    localparam int TO = 8;

    localparam int EV_TRIG = 0;
    localparam int EV_ENLEN = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR = 3;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } ev_t;

    logic                 pdh_clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 arm_i = 1'b0;
    logic                 abort_i = 1'b0;
    logic [1:0]           trig_mode_i = 2'd0;
    logic signed [TW-1:0] trig_src_i = '0;
    logic                 trig_ext_i = 1'b0;
    logic signed [TW-1:0] threshold_i = '0;
    logic [HW-1:0]        holdoff_i = '0;
    logic [15:0]          ch_a_i = '0;
    logic [15:0]          ch_b_i = '0;
    logic [15:0]          ch_c_i = '0;
    logic [15:0]          ch_d_i = '0;
    logic                 bram_ready_i = 1'b1;
    logic                 enable_o;
    logic [63:0]          data_o;
    logic                 armed_o;
    logic                 done_o;
    logic                 err_o;
    logic [31:0]          trig_ts_o;

    ev_t         evq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cyc = '0;
    logic [63:0] exp_data = '0;

    int eng_drop = 2;
    int eng_busy_len = 10;
    bit eng_low = 1'b0;
    int eng_busy = 0;
    int eng_seen = 0;

    always #5 pdh_clk = ~pdh_clk;

    capture_trigger #(
        .TW(TW),
        .HW(HW),
        .START_TIMEOUT(TO)
    ) dut (
        .pdh_clk     (pdh_clk),
        .rst_i       (rst_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .trig_mode_i (trig_mode_i),
        .trig_src_i  (trig_src_i),
        .trig_ext_i  (trig_ext_i),
        .threshold_i (threshold_i),
        .holdoff_i   (holdoff_i),
        .ch_a_i      (ch_a_i),
        .ch_b_i      (ch_b_i),
        .ch_c_i      (ch_c_i),
        .ch_d_i      (ch_d_i),
        .bram_ready_i(bram_ready_i),
        .enable_o    (enable_o),
        .data_o      (data_o),
        .armed_o     (armed_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .trig_ts_o   (trig_ts_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        evq.push_back(e);
    endtask

    task automatic pop_expect(input int kind, input logic [63:0] val);
        ev_t e;
        n_cmp++;
        if (evq.size() == 0) begin
            n_bad++;
            $display("FAIL event: unexpected kind %0d value %0h at t=%0t", kind, val, $time);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_bad++;
                $display("FAIL event: got kind %0d value %0h expected kind %0d value %0h at t=%0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    task automatic step();
        @(posedge pdh_clk);
        #1;
        ch_a_i = 16'($urandom);
        ch_b_i = 16'($urandom);
        ch_c_i = 16'($urandom);
        ch_d_i = 16'($urandom);
    endtask

    // Reference: index of the first ARMED sample that fires, or -1.
    function automatic int model_hit(input int mode, input int thr, input int s[$], input bit e[$]);
        for (int k = 0; k < s.size(); k++) begin
            case (mode)
                0: return 0;
                1: if (k > 0 && s[k-1] < thr && s[k] >= thr) return k;
                2: if (k > 0 && s[k-1] > thr && s[k] <= thr) return k;
                default: if (e[k]) return k;
            endcase
        end
        return -1;
    endfunction

    // Timestamp and capture-word reference, compared every cycle.
    initial begin
        forever begin
            @(posedge pdh_clk);
            if (rst_i) begin
                cyc      = '0;
                exp_data = '0;
            end else begin
                cyc      = cyc + 1;
                exp_data = {ch_a_i, ch_b_i, ch_c_i, ch_d_i};
            end
            @(negedge pdh_clk);
            check("data_o", data_o, exp_data);
        end
    end

    // Event monitor.
    initial begin
        bit en_prev = 1'b0;
        bit err_prev = 1'b0;
        int en_len = 0;
        forever begin
            @(negedge pdh_clk);
            if (enable_o && !en_prev) begin
                pop_expect(EV_TRIG, 64'(trig_ts_o));
                en_len = 0;
            end
            if (enable_o) en_len++;
            if (!enable_o && en_prev) pop_expect(EV_ENLEN, 64'(en_len));
            if (err_o && !err_prev) pop_expect(EV_ERR, 64'd0);
            if (done_o) pop_expect(EV_DONE, 64'd0);
            en_prev  = enable_o;
            err_prev = err_o;
        end
    end

    // Capture engine model.
    initial begin
        forever begin
            @(negedge pdh_clk);
            if (rst_i) begin
                bram_ready_i = 1'b1;
                eng_busy     = 0;
                eng_seen     = 0;
            end else if (eng_low) begin
                bram_ready_i = 1'b0;
            end else if (eng_busy > 0) begin
                eng_busy--;
                if (eng_busy == 0) begin
                    bram_ready_i = 1'b1;
                    eng_seen     = 0;
                end
            end else if (enable_o) begin
                eng_seen++;
                if (eng_drop != 0 && eng_seen == eng_drop) begin
                    bram_ready_i = 1'b0;
                    eng_busy     = eng_busy_len;
                end
            end else begin
                bram_ready_i = 1'b1;
                eng_seen     = 0;
            end
        end
    end

    task automatic wait_quiet(input string name);
        int w;
        w = 0;
        while (w < 400 && !(evq.size() == 0 && !armed_o && !enable_o && eng_busy == 0 && bram_ready_i)) begin
            step();
            w++;
        end
        check({name, "_settle"}, 64'(w < 400), 64'd1);
    endtask

    task automatic run_trig(input string name, input int mode, input int thr, input int h,
                            input int s[$], input bit e[$], input int abort_in,
                            input int drop, input int busy);
        int          n;
        int          hit;
        int          abort_at;
        int          stop;
        int          armed_cnt;
        bit          aborted;
        logic [31:0] a_cyc;
        n         = s.size();
        hit       = model_hit(mode, thr, s, e);
        abort_at  = abort_in;
        armed_cnt = 0;
        if (hit < 0 && abort_at < 0) abort_at = n;
        aborted = (abort_at >= 0) && (hit < 0 || abort_at <= hit);
        stop    = aborted ? abort_at : hit;
        trig_mode_i  = 2'(mode);
        threshold_i  = TW'(thr);
        holdoff_i    = HW'(h);
        eng_drop     = drop;
        eng_busy_len = busy;
        trig_src_i   = TW'(s[0]);
        trig_ext_i   = e[0];
        arm_i        = 1'b1;
        a_cyc        = cyc;
        if (!aborted) begin
            push(EV_TRIG, 64'(a_cyc + 32'(1 + h + hit)));
            push(EV_ENLEN, 64'(drop == 0 ? TO : drop));
            push(drop == 0 ? EV_ERR : EV_DONE, 64'd0);
        end
        step();
        arm_i = 1'b0;
        if (armed_o) armed_cnt++;
        check({name, "_err_clr"}, 64'(err_o), 64'd0);
        repeat (h) begin
            step();
            if (armed_o) armed_cnt++;
        end
        for (int k = 0; k <= n; k++) begin
            trig_src_i = TW'(k < n ? s[k] : s[n-1]);
            trig_ext_i = (k < n) ? e[k] : 1'b0;
            abort_i    = (k == abort_at);
            step();
            if (armed_o) armed_cnt++;
        end
        abort_i    = 1'b0;
        trig_ext_i = 1'b0;
        for (int w = 0; w < 400 && armed_o; w++) begin
            step();
            if (armed_o) armed_cnt++;
        end
        check({name, "_armed_cycles"}, 64'(armed_cnt), 64'(h + stop + 1));
        wait_quiet(name);
    endtask

    initial begin
        int s[$];
        bit e[$];
        logic [31:0] a_cyc;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[$];
        bit e[$];
        logic [31:0] a_cyc;
        repeat (3) step();
        check("rst_enable", 64'(enable_o), 64'd0);
        check("rst_armed", 64'(armed_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_ts", 64'(trig_ts_o), 64'd0);
        rst_i = 1'b0;
        repeat (2) step();

        s = '{0}; e = '{0};
        run_trig("imm_done", 0, 0, 0, s, e, -1, 2, 100);

        s = '{-50, 0, 50, 99, 100}; e = '{0, 0, 0, 0, 0};
        run_trig("rise_ramp", 1, 100, 0, s, e, -1, 2, 20);

        s = '{200, 200, 0, 150}; e = '{0, 0, 0, 0};
        run_trig("rise_preset", 1, 100, 2, s, e, -1, 1, 5);

        s = '{20, -9, -10}; e = '{0, 0, 0};
        run_trig("fall", 2, -10, 0, s, e, -1, 3, 4);

        s = '{0}; e = '{1};
        run_trig("ext_holdoff", 3, 0, 10, s, e, -1, 2, 6);

        s = '{0}; e = '{0};
        run_trig("timeout", 0, 0, 0, s, e, -1, 0, 0);

        s = '{5}; e = '{0};
        run_trig("after_err", 0, 0, 1, s, e, -1, 1, 3);

        s = '{0}; e = '{1};
        run_trig("abort_ext", 3, 0, 0, s, e, 0, 2, 5);

        s = '{0}; e = '{0};
        run_trig("abort_imm", 0, 0, 3, s, e, 0, 2, 5);

        eng_low = 1'b1;
        repeat (2) step();
        arm_i = 1'b1;
        push(EV_ERR, 64'd0);
        step();
        arm_i = 1'b0;
        repeat (2) step();
        check("reject_armed", 64'(armed_o), 64'd0);
        check("reject_err", 64'(err_o), 64'd1);
        eng_low = 1'b0;
        wait_quiet("reject");

        for (int it = 0; it < 14; it++) begin
            int mode;
            int thr;
            int h;
            int n;
            int ab;
            int drop;
            mode = int'($urandom_range(0, 3));
            thr  = int'($urandom_range(0, 40)) - 20;
            h    = int'($urandom_range(0, 4));
            n    = int'($urandom_range(2, 10));
            s.delete();
            e.delete();
            for (int k = 0; k < n; k++) begin
                s.push_back(thr + int'($urandom_range(0, 8)) - 4);
                e.push_back($urandom_range(0, 5) == 0);
            end
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            drop = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
            run_trig("rand", mode, thr, h, s, e, ab, drop, int'($urandom_range(1, 20)));
        end

        trig_mode_i  = 2'd0;
        holdoff_i    = '0;
        eng_drop     = 1;
        eng_busy_len = 300;
        arm_i        = 1'b1;
        a_cyc        = cyc;
        push(EV_TRIG, 64'(a_cyc + 32'd1));
        push(EV_ENLEN, 64'd1);
        step();
        arm_i = 1'b0;
        repeat (10) step();
        check("wd_queue", 64'(evq.size()), 64'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("wd_rst_enable", 64'(enable_o), 64'd0);
        check("wd_rst_armed", 64'(armed_o), 64'd0);
        check("wd_rst_done", 64'(done_o), 64'd0);
        check("wd_rst_err", 64'(err_o), 64'd0);
        check("wd_rst_ts", 64'(trig_ts_o), 64'd0);
        check("wd_rst_data", data_o, 64'd0);
        repeat (5) step();
        check("wd_no_done", 64'(done_o), 64'd0);

        s = '{0}; e = '{0};
        run_trig("post_rst", 0, 0, 0, s, e, -1, 2, 8);

        check("final_queue", 64'(evq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
